// File: rtl/ac97_codec_sequencer.sv
// AC'97 codec bring-up sequencer: holds codec reset, waits for codec ready,
// programs the default mixer/rate registers, then forwards CPU register writes.
module ac97_codec_sequencer #(
    parameter int unsigned RESET_HOLD_CYCLES    = 5000,
    parameter int unsigned READY_TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        codec_ready,
    input  logic        reinit,
    input  logic        cpu_cmd_valid,
    input  logic [6:0]  cpu_cmd_addr,
    input  logic [15:0] cpu_cmd_data,
    output logic        cpu_cmd_ready,
    output logic        cmd_valid,
    output logic [6:0]  cmd_addr,
    output logic [15:0] cmd_data,
    input  logic        cmd_ready,
    output logic        reset_b,
    output logic        init_done,
    output logic        init_error
);

    localparam int unsigned MAX_CYCLES = (RESET_HOLD_CYCLES > READY_TIMEOUT_CYCLES) ?
                                         RESET_HOLD_CYCLES : READY_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READY_TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_HOLD       = 3'd0;
    localparam logic [2:0] S_WAIT_READY = 3'd1;
    localparam logic [2:0] S_INIT       = 3'd2;
    localparam logic [2:0] S_RUN        = 3'd3;
    localparam logic [2:0] S_ERROR      = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_reinit_pend;
    logic             r_reset_b;
    logic             r_cmd_valid;
    logic [6:0]       r_cmd_addr;
    logic [15:0]      r_cmd_data;
    logic             r_cpu_cmd_ready;
    logic             r_init_done;
    logic             r_init_error;

    logic             w_xfer;
    logic             w_cpu_accept;
    logic             w_reinit_req;
    logic             w_go_hold;
    logic [1:0]       w_idx_next;
    logic [22:0]      w_init_first;
    logic [22:0]      w_init_next;

    // Default register image written during bring-up, {addr, data}.
    function automatic logic [22:0] init_word(input logic [1:0] idx);
        case (idx)
            2'd0:    init_word = {7'h02, 16'h0000};
            2'd1:    init_word = {7'h18, 16'h0808};
            2'd2:    init_word = {7'h2A, 16'h0001};
            default: init_word = {7'h2C, 16'hBB80};
        endcase
    endfunction

    assign w_xfer       = r_cmd_valid & cmd_ready;
    assign w_cpu_accept = r_cpu_cmd_ready & cpu_cmd_valid;
    assign w_reinit_req = reinit | r_reinit_pend;
    assign w_idx_next   = r_idx + 2'd1;
    assign w_init_first = init_word(2'd0);
    assign w_init_next  = init_word(w_idx_next);

    // A reinit arriving together with a CPU acceptance is deferred behind that
    // write so an accepted command is never silently discarded.
    always_comb begin
        w_go_hold = 1'b0;
        case (r_state)
            S_RUN:   w_go_hold = r_cmd_valid ? (w_xfer & w_reinit_req) : (reinit & ~w_cpu_accept);
            S_ERROR: w_go_hold = reinit;
            S_HOLD, S_WAIT_READY, S_INIT: w_go_hold = 1'b0;
            default: w_go_hold = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state         <= S_HOLD;
            r_cnt           <= '0;
            r_idx           <= '0;
            r_reinit_pend   <= 1'b0;
            r_reset_b       <= 1'b0;
            r_cmd_valid     <= 1'b0;
            r_cmd_addr      <= '0;
            r_cmd_data      <= '0;
            r_cpu_cmd_ready <= 1'b0;
            r_init_done     <= 1'b0;
            r_init_error    <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state   <= S_WAIT_READY;
                        r_cnt     <= '0;
                        r_reset_b <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_READY: begin
                    if (codec_ready) begin
                        r_state     <= S_INIT;
                        r_cnt       <= '0;
                        r_idx       <= '0;
                        r_cmd_valid <= 1'b1;
                        {r_cmd_addr, r_cmd_data} <= w_init_first;
                    end else if (r_cnt == WAIT_LAST) begin
                        r_state      <= S_ERROR;
                        r_cnt        <= '0;
                        r_init_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_INIT: begin
                    if (w_xfer) begin
                        if (r_idx == 2'd3) begin
                            r_state         <= S_RUN;
                            r_cmd_valid     <= 1'b0;
                            r_cpu_cmd_ready <= 1'b1;
                            r_init_done     <= 1'b1;
                        end else begin
                            r_idx <= w_idx_next;
                            {r_cmd_addr, r_cmd_data} <= w_init_next;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cmd_valid) begin
                        if (w_xfer) begin
                            r_cmd_valid     <= 1'b0;
                            r_cpu_cmd_ready <= 1'b1;
                        end else if (reinit) begin
                            r_reinit_pend <= 1'b1;
                        end
                    end else if (w_cpu_accept) begin
                        r_cmd_valid     <= 1'b1;
                        r_cmd_addr      <= cpu_cmd_addr;
                        r_cmd_data      <= cpu_cmd_data;
                        r_cpu_cmd_ready <= 1'b0;
                        if (reinit) begin
                            r_reinit_pend <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (w_go_hold) begin
                r_state         <= S_HOLD;
                r_cnt           <= '0;
                r_idx           <= '0;
                r_reinit_pend   <= 1'b0;
                r_reset_b       <= 1'b0;
                r_cmd_valid     <= 1'b0;
                r_cpu_cmd_ready <= 1'b0;
                r_init_done     <= 1'b0;
                r_init_error    <= 1'b0;
            end
        end
    end

    assign cpu_cmd_ready = r_cpu_cmd_ready;
    assign cmd_valid     = r_cmd_valid;
    assign cmd_addr      = r_cmd_addr;
    assign cmd_data      = r_cmd_data;
    assign reset_b       = r_reset_b;
    assign init_done     = r_init_done;
    assign init_error    = r_init_error;

endmodule

// File: tb/tb_ac97_codec_sequencer.sv
// Directed scoreboard bench for ac97_codec_sequencer (short hold/timeout).
`timescale 1ns/1ps
module tb_ac97_codec_sequencer;

    localparam int unsigned HOLD = 4;
    localparam int unsigned TMO  = 10;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        codec_ready;
    logic        reinit;
    logic        cpu_cmd_valid;
    logic [6:0]  cpu_cmd_addr;
    logic [15:0] cpu_cmd_data;
    logic        cpu_cmd_ready;
    logic        cmd_valid;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_ready;
    logic        reset_b;
    logic        init_done;
    logic        init_error;

    typedef struct packed {
        logic [6:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_xfer = 0;
    int          n_acc  = 0;
    logic        prev_pend = 1'b0;
    logic [6:0]  prev_a = '0;
    logic [15:0] prev_d = '0;

    always #5 clk = ~clk;

    ac97_codec_sequencer #(
        .RESET_HOLD_CYCLES    (HOLD),
        .READY_TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .codec_ready   (codec_ready),
        .reinit        (reinit),
        .cpu_cmd_valid (cpu_cmd_valid),
        .cpu_cmd_addr  (cpu_cmd_addr),
        .cpu_cmd_data  (cpu_cmd_data),
        .cpu_cmd_ready (cpu_cmd_ready),
        .cmd_valid     (cmd_valid),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .reset_b       (reset_b),
        .init_done     (init_done),
        .init_error    (init_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transfers are popped from the scoreboard; stalled offers must hold steady.
    always @(negedge clk) begin
        if (prev_pend) begin
            check("stall_valid", 32'(cmd_valid), 32'd1);
            check("stall_addr", 32'(cmd_addr), 32'(prev_a));
            check("stall_data", 32'(cmd_data), 32'(prev_d));
        end
        if (rst_b === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            n_xfer++;
            check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("xfer_addr", 32'(cmd_addr), 32'(mon_e.a));
                check("xfer_data", 32'(cmd_data), 32'(mon_e.d));
            end
        end
        if (rst_b === 1'b1 && cpu_cmd_valid === 1'b1 && cpu_cmd_ready === 1'b1) n_acc++;
        prev_pend = (rst_b === 1'b1) && (cmd_valid === 1'b1) && (cmd_ready === 1'b0);
        prev_a    = cmd_addr;
        prev_d    = cmd_data;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push(7'h02, 16'h0000);
        push(7'h18, 16'h0808);
        push(7'h2A, 16'h0001);
        push(7'h2C, 16'hBB80);
    endtask

    task automatic check_reset(input string p);
        check({p, "_reset_b"}, 32'(reset_b), 32'd0);
        check({p, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({p, "_cmd_addr"}, 32'(cmd_addr), 32'd0);
        check({p, "_cmd_data"}, 32'(cmd_data), 32'd0);
        check({p, "_cpu_ready"}, 32'(cpu_cmd_ready), 32'd0);
        check({p, "_init_done"}, 32'(init_done), 32'd0);
        check({p, "_init_error"}, 32'(init_error), 32'd0);
    endtask

    task automatic measure_hold(input string tag);
        int lo = 0;
        for (int k = 0; k < 20 && reset_b === 1'b0; k++) begin
            lo++;
            cyc();
        end
        check(tag, 32'(lo), 32'(HOLD));
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 40 && init_done !== 1'b1; k++) cyc();
        check(tag, 32'(init_done), 32'd1);
    endtask

    task automatic wait_addr(input string tag, input logic [6:0] a);
        for (int k = 0; k < 40 && !(cmd_valid === 1'b1 && cmd_addr === a); k++) cyc();
        check(tag, 32'(cmd_valid === 1'b1 && cmd_addr === a), 32'd1);
    endtask

    task automatic cpu_write(input string tag, input logic [6:0] a, input logic [15:0] d,
                             output int cycles);
        logic acc;
        acc    = 1'b0;
        cycles = 0;
        push(a, d);
        cpu_cmd_valid = 1'b1;
        cpu_cmd_addr  = a;
        cpu_cmd_data  = d;
        for (int k = 0; k < 40; k++) begin
            acc = cpu_cmd_ready;
            cyc();
            cycles++;
            if (acc) break;
        end
        check(tag, 32'(acc), 32'd1);
        cpu_cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int xb;
        int c1;
        int c2;
        int c3;
        int w;
        logic seen_valid;
        logic acc;

        rst_b = 1'b0; codec_ready = 1'b1; reinit = 1'b0; cmd_ready = 1'b1;
        cpu_cmd_valid = 1'b0; cpu_cmd_addr = '0; cpu_cmd_data = '0;
        repeat (3) cyc();
        check_reset("por");

        // Power-on bring-up with everything ready
        push_init();
        rst_b = 1'b1;
        measure_hold("hold_len_por");
        wait_done("init_done_por");
        check("por_all_written", 32'(exp_q.size()), 32'd0);
        check("por_xfer_count", 32'(n_xfer), 32'd4);
        check("run_cpu_ready", 32'(cpu_cmd_ready), 32'd1);
        check("run_cmd_idle", 32'(cmd_valid), 32'd0);

        // CPU write stalled by the serializer
        acc0 = n_acc;
        cmd_ready = 1'b0;
        push(7'h04, 16'h1F1F);
        cpu_cmd_valid = 1'b1; cpu_cmd_addr = 7'h04; cpu_cmd_data = 16'h1F1F;
        cyc();
        check("cpu_fwd_valid", 32'(cmd_valid), 32'd1);
        check("cpu_fwd_addr", 32'(cmd_addr), 32'h04);
        check("cpu_fwd_data", 32'(cmd_data), 32'h1F1F);
        for (int i = 0; i < 3; i++) begin
            check("cpu_ready_pending", 32'(cpu_cmd_ready), 32'd0);
            cyc();
        end
        cpu_cmd_valid = 1'b0;
        cmd_ready = 1'b1;
        cyc();
        check("cpu_single_accept", 32'(n_acc - acc0), 32'd1);
        check("cpu_xfer_count", 32'(n_xfer), 32'd5);
        check("cpu_ready_after", 32'(cpu_cmd_ready), 32'd1);

        // Back-to-back CPU writes: one every two cycles
        cpu_write("tp_acc1", 7'h06, 16'h0A0A, c1);
        cpu_write("tp_acc2", 7'h08, 16'h0B0B, c2);
        cpu_write("tp_acc3", 7'h0A, 16'h0C0C, c3);
        cyc();
        check("tp_gap2", 32'(c2), 32'd2);
        check("tp_gap3", 32'(c3), 32'd2);
        check("tp_drained", 32'(exp_q.size()), 32'd0);

        // codec_ready loss in RUN is ignored
        codec_ready = 1'b0;
        repeat (3) cyc();
        check("ready_loss_done", 32'(init_done), 32'd1);
        check("ready_loss_reset_b", 32'(reset_b), 32'd1);
        check("ready_loss_cpu_ready", 32'(cpu_cmd_ready), 32'd1);
        codec_ready = 1'b1;

        // reinit while a RUN write is stalled
        cmd_ready = 1'b0;
        push(7'h0C, 16'h5555);
        cpu_cmd_valid = 1'b1; cpu_cmd_addr = 7'h0C; cpu_cmd_data = 16'h5555;
        cyc();
        cpu_cmd_valid = 1'b0;
        reinit = 1'b1;
        cyc();
        reinit = 1'b0;
        repeat (2) cyc();
        check("reinit_defer_reset_b", 32'(reset_b), 32'd1);
        check("reinit_defer_done", 32'(init_done), 32'd1);
        check("reinit_defer_valid", 32'(cmd_valid), 32'd1);
        push_init();
        cmd_ready = 1'b1;
        xb = n_xfer;
        cyc();
        check("reinit_xfer_first", 32'(n_xfer - xb), 32'd1);
        for (int k = 0; k < 3 && reset_b !== 1'b0; k++) cyc();
        check("reinit_hold_reset_b", 32'(reset_b), 32'd0);
        check("reinit_done_clear", 32'(init_done), 32'd0);
        measure_hold("hold_len_reinit");

        // Stall INIT write 2 for five cycles; reinit in INIT is ignored
        wait_addr("w1_offer", 7'h02);
        cyc();
        check("w2_next_cycle", 32'(cmd_valid === 1'b1 && cmd_addr === 7'h18), 32'd1);
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("w2_stall_valid", 32'(cmd_valid), 32'd1);
            check("w2_stall_addr", 32'(cmd_addr), 32'h18);
            check("w2_stall_data", 32'(cmd_data), 32'h0808);
            reinit = (i == 2);
            cyc();
        end
        reinit = 1'b0;
        check("init_reinit_ignored", 32'(reset_b), 32'd1);
        cmd_ready = 1'b1;
        cyc();
        check("w3_valid", 32'(cmd_valid), 32'd1);
        check("w3_addr", 32'(cmd_addr), 32'h2A);
        check("w3_data", 32'(cmd_data), 32'h0001);
        wait_done("init_done_stall");
        check("stall_all_written", 32'(exp_q.size()), 32'd0);

        // codec_ready timeout
        codec_ready = 1'b0;
        rst_b = 1'b0;
        cyc();
        rst_b = 1'b1;
        measure_hold("hold_len_tmo");
        w = 0;
        seen_valid = 1'b0;
        for (int k = 0; k < 40 && init_error !== 1'b1; k++) begin
            if (cmd_valid !== 1'b0) seen_valid = 1'b1;
            w++;
            cyc();
        end
        check("tmo_wait_cycles", 32'(w), 32'(TMO));
        check("tmo_init_error", 32'(init_error), 32'd1);
        check("tmo_reset_b", 32'(reset_b), 32'd1);
        check("tmo_cmd_valid", 32'(cmd_valid), 32'd0);
        check("tmo_no_valid_seen", 32'(seen_valid), 32'd0);

        // CPU request pending in ERROR is not accepted, then served after reinit
        acc0 = n_acc;
        cpu_cmd_valid = 1'b1; cpu_cmd_addr = 7'h0E; cpu_cmd_data = 16'hABCD;
        repeat (3) cyc();
        check("err_cpu_ready", 32'(cpu_cmd_ready), 32'd0);
        check("err_no_accept", 32'(n_acc - acc0), 32'd0);
        check("err_still_error", 32'(init_error), 32'd1);
        push_init();
        push(7'h0E, 16'hABCD);
        reinit = 1'b1;
        cyc();
        reinit = 1'b0;
        codec_ready = 1'b1;
        check("err_reinit_reset_b", 32'(reset_b), 32'd0);
        check("err_reinit_error_clr", 32'(init_error), 32'd0);
        measure_hold("hold_len_err");
        wait_done("init_done_err");
        acc = 1'b0;
        for (int k = 0; k < 40; k++) begin
            acc = cpu_cmd_ready;
            cyc();
            if (acc) break;
        end
        check("pending_cpu_accepted", 32'(acc), 32'd1);
        cpu_cmd_valid = 1'b0;
        cyc();
        check("pending_cpu_once", 32'(n_acc - acc0), 32'd1);
        check("err_all_written", 32'(exp_q.size()), 32'd0);

        // rst_b during INIT write 3
        rst_b = 1'b0;
        cyc();
        rst_b = 1'b1;
        push(7'h02, 16'h0000);
        push(7'h18, 16'h0808);
        wait_addr("w3_offer_pre_rst", 7'h2A);
        cmd_ready = 1'b0;
        rst_b = 1'b0;
        cyc();
        check_reset("mid");
        push_init();
        rst_b = 1'b1;
        cmd_ready = 1'b1;
        measure_hold("hold_len_mid");
        wait_addr("restart_w1", 7'h02);
        wait_done("init_done_mid");
        check("final_all_written", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
